// File: rtl/grasshopper_pkg.sv
// Shared types and helpers for the grasshopper stream front-end.
package grasshopper_pkg;

    localparam int unsigned BLOCK_W = 128;

    typedef logic [BLOCK_W-1:0] block_t;

    typedef enum logic {
        MODE_ECB = 1'b0,
        MODE_CTR = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_ACK  = 2'd3
    } gh_ctrl_state_e;

    // Increment only the low w bits of a counter block; the upper prefix never
    // receives a carry.
    function automatic block_t ctr_inc(input block_t c, input int unsigned w);
        block_t mask;
        mask = (w >= BLOCK_W) ? '1 : ((block_t'(1) << w) - block_t'(1));
        return (c & ~mask) | ((c + block_t'(1)) & mask);
    endfunction

endpackage

// File: rtl/gh_sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two.
module gh_sync_fifo #(
    parameter int unsigned WIDTH = 129,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage array, written on an accepted push.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/grasshopper_mode_ctrl.sv
// ECB/CTR stream front-end for the grasshopper core: one block in flight,
// results buffered in an output FIFO so downstream stalls never block the core.
module grasshopper_mode_ctrl
    import grasshopper_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CTR_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode_i,
    input  logic [BLOCK_W-1:0] iv_i,
    input  logic               s_valid_i,
    output logic               s_ready_o,
    input  logic [BLOCK_W-1:0] s_data_i,
    input  logic               s_last_i,
    output logic               m_valid_o,
    input  logic               m_ready_i,
    output logic [BLOCK_W-1:0] m_data_o,
    output logic               m_last_o,
    output logic [BLOCK_W-1:0] core_data_o,
    output logic               core_request_o,
    output logic               core_ack_o,
    input  logic [BLOCK_W-1:0] core_data_i,
    input  logic               core_valid_i,
    input  logic               core_busy_i
);

    gh_ctrl_state_e r_state;
    block_t         r_block;
    logic           r_last;
    mode_e          r_mode;
    block_t         r_ctr;
    logic           r_first;
    block_t         r_core_data;
    logic           r_req;
    logic           r_ack;

    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    mode_e                 w_mode_sel;
    block_t                w_ctr_sel;
    logic [BLOCK_W:0]      w_push_data;
    logic [BLOCK_W:0]      w_head;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [$clog2(DEPTH):0] w_fifo_count;

    // A first block takes mode and IV from the ports; later blocks use the
    // latched message context.
    assign w_mode_sel = r_first ? mode_e'(mode_i) : r_mode;
    assign w_ctr_sel  = r_first ? iv_i : r_ctr;

    assign s_ready_o   = !rst && (r_state == ST_IDLE) && !core_busy_i && !w_fifo_full;
    assign w_accept    = s_valid_i && s_ready_o;
    assign w_push      = (r_state == ST_WAIT) && core_valid_i;
    assign w_pop       = m_valid_o && m_ready_i;
    assign w_push_data = {r_last, (r_mode == MODE_CTR) ? (core_data_i ^ r_block) : core_data_i};

    assign m_valid_o      = (w_fifo_count != '0);
    assign m_data_o       = w_fifo_empty ? '0 : w_head[BLOCK_W-1:0];
    assign m_last_o       = !w_fifo_empty && w_head[BLOCK_W];
    assign core_data_o    = r_core_data;
    assign core_request_o = r_req;
    assign core_ack_o     = r_ack;

    // Core handshake sequencer: IDLE -> REQ -> WAIT -> ACK, with registered strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_block     <= '0;
            r_last      <= 1'b0;
            r_mode      <= MODE_ECB;
            r_ctr       <= '0;
            r_first     <= 1'b1;
            r_core_data <= '0;
            r_req       <= 1'b0;
            r_ack       <= 1'b0;
        end else begin
            r_req <= 1'b0;
            r_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_block     <= s_data_i;
                        r_last      <= s_last_i;
                        r_first     <= s_last_i;
                        r_mode      <= w_mode_sel;
                        r_ctr       <= w_ctr_sel;
                        r_core_data <= (w_mode_sel == MODE_CTR) ? w_ctr_sel : s_data_i;
                        r_req       <= 1'b1;
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_valid_i) begin
                        r_ctr   <= ctr_inc(r_ctr, CTR_W);
                        r_ack   <= 1'b1;
                        r_state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    gh_sync_fifo #(
        .WIDTH (BLOCK_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_push_data),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

endmodule

// File: tb/tb_grasshopper_mode_ctrl.sv
// Bench for grasshopper_mode_ctrl: a stand-in core, a stream-level reference
// model, per-cycle output checks, and directed literal checks.
module tb_grasshopper_mode_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam logic [127:0] GOST_PT = 128'h1122334455667700ffeeddccbbaa9988;
    localparam logic [127:0] GOST_CT = 128'h7f679d90bebc24305a468d42b9d4edcd;
    localparam logic [127:0] IV1 = 128'h1234567890abcef0_0000000000000000;
    localparam logic [127:0] IV2 = 128'hfedcba9876543210_00000000000000ff;

    logic clk = 1'b0;
    logic rst;
    logic mode_i;
    logic [127:0] iv_i;
    logic s_valid_i;
    logic [127:0] s_data_i;
    logic s_last_i;
    logic m_ready_i;
    logic [127:0] core_data_i;
    logic core_valid_i;
    logic core_busy_i;

    logic s_ready_o, m_valid_o, m_last_o, core_request_o, core_ack_o;
    logic [127:0] m_data_o, core_data_o;
    logic s_ready8, m_valid8, m_last8, core_req8, core_ack8;
    logic [127:0] m_data8, core_data8;

    always #5 clk = ~clk;

    grasshopper_mode_ctrl #(.DEPTH(DEPTH), .CTR_W(64)) u_dut (
        .clk(clk), .rst(rst), .mode_i(mode_i), .iv_i(iv_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i), .s_last_i(s_last_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o), .m_last_o(m_last_o),
        .core_data_o(core_data_o), .core_request_o(core_request_o), .core_ack_o(core_ack_o),
        .core_data_i(core_data_i), .core_valid_i(core_valid_i), .core_busy_i(core_busy_i)
    );

    // Narrow-counter instance; shares the stream and the core responses.
    grasshopper_mode_ctrl #(.DEPTH(DEPTH), .CTR_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .mode_i(mode_i), .iv_i(iv_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready8), .s_data_i(s_data_i), .s_last_i(s_last_i),
        .m_valid_o(m_valid8), .m_ready_i(m_ready_i), .m_data_o(m_data8), .m_last_o(m_last8),
        .core_data_o(core_data8), .core_request_o(core_req8), .core_ack_o(core_ack8),
        .core_data_i(core_data_i), .core_valid_i(core_valid_i), .core_busy_i(core_busy_i)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [128:0] a, input logic [128:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // Stand-in cipher: the GOST test vector maps exactly, everything else is
    // an arbitrary fixed bijection.
    function automatic logic [127:0] core_f(input logic [127:0] x);
        if (x == GOST_PT) return GOST_CT;
        return {x[86:0], x[127:87]} ^ 128'h0123456789abcdef_fedcba9876543210;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stand-in core ----------------
    logic cm_valid = 1'b0;
    logic stray = 1'b0;
    logic cm_pend = 1'b0;
    int   cm_wait = 0;
    int   lat_fix = -1;
    logic [127:0] cm_res = '0;
    assign core_valid_i = cm_valid | stray;

    initial begin
        core_data_i = '0;
        forever begin
            @(posedge clk); #1;
            cm_valid = 1'b0;
            if (rst) begin
                cm_pend = 1'b0;
            end else begin
                if (cm_pend) begin
                    if (cm_wait == 0) begin
                        cm_valid = 1'b1;
                        core_data_i = cm_res;
                        cm_pend = 1'b0;
                    end else begin
                        cm_wait--;
                    end
                end
                if (core_request_o) begin
                    cm_pend = 1'b1;
                    cm_wait = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
                    cm_res = core_f(core_data_o);
                end
            end
        end
    end

    // ---------------- reference model and compare ----------------
    logic [127:0] q_cin[$];
    logic [127:0] q_cin8[$];
    logic [128:0] q_out[$];
    logic [128:0] out_log[$];
    logic [127:0] req_log[$];
    logic [127:0] req8_log[$];
    logic m_first, m_mode;
    logic [127:0] m_ctr, m_ctr8;
    logic m_req_due, m_wait, m_ack_due, m_txn;
    int   m_n;
    int   req_cnt = 0, ack_cnt = 0, acc_cnt = 0;

    always @(negedge clk) begin
        logic acc, push, pop, exp_ready;
        logic [127:0] cin, cin8, res;
        logic [128:0] head;
        if (rst) begin
            chk("rst_s_ready", 129'(s_ready_o), 129'(0));
            chk("rst_req", 129'(core_request_o), 129'(0));
            chk("rst_ack", 129'(core_ack_o), 129'(0));
            chk("rst_m_valid", 129'(m_valid_o), 129'(0));
            chk("rst_m_last", 129'(m_last_o), 129'(0));
            chk("rst_m_data", 129'(m_data_o), 129'(0));
            chk("rst_core_data", 129'(core_data_o), 129'(0));
            chk("rst_s_ready8", 129'(s_ready8), 129'(0));
            chk("rst_m_valid8", 129'({m_valid8, m_last8, core_req8, core_ack8}), 129'(0));
            chk("rst_data8", 129'(m_data8 | core_data8), 129'(0));
            q_cin.delete(); q_cin8.delete(); q_out.delete();
            m_first = 1'b1; m_mode = 1'b0; m_ctr = '0; m_ctr8 = '0;
            m_req_due = 1'b0; m_wait = 1'b0; m_ack_due = 1'b0; m_txn = 1'b0; m_n = 0;
        end else begin
            exp_ready = !core_busy_i && !m_txn && (m_n < DEPTH);
            chk("s_ready", 129'(s_ready_o), 129'(exp_ready));
            chk("s_ready8", 129'(s_ready8), 129'(exp_ready));
            chk("core_request", 129'(core_request_o), 129'(m_req_due));
            chk("core_request8", 129'(core_req8), 129'(m_req_due));
            chk("core_ack", 129'(core_ack_o), 129'(m_ack_due));
            chk("core_ack8", 129'(core_ack8), 129'(m_ack_due));
            chk("m_valid", 129'(m_valid_o), 129'(m_n != 0));
            chk("m_valid8", 129'(m_valid8), 129'(m_n != 0));
            if (core_request_o) begin
                req_cnt++;
                req_log.push_back(core_data_o);
                chk("core_data", 129'(core_data_o), 129'(q_cin.size() > 0 ? q_cin[0] : 'x));
                if (q_cin.size() > 0) void'(q_cin.pop_front());
            end
            if (core_req8) begin
                req8_log.push_back(core_data8);
                chk("core_data8", 129'(core_data8), 129'(q_cin8.size() > 0 ? q_cin8[0] : 'x));
                if (q_cin8.size() > 0) void'(q_cin8.pop_front());
            end
            if (core_ack_o) ack_cnt++;
            head = (q_out.size() > 0) ? q_out[0] : 'x;
            if (m_valid_o) chk("m_out", {m_last_o, m_data_o}, head);
            if (m_valid8)  chk("m_out8", {m_last8, m_data8}, head);
            // next-cycle bookkeeping
            acc  = s_valid_i && s_ready_o;
            push = m_wait && core_valid_i;
            pop  = m_valid_o && m_ready_i;
            if (pop) begin
                out_log.push_back({m_last_o, m_data_o});
                if (q_out.size() > 0) void'(q_out.pop_front());
            end
            if (acc) begin
                acc_cnt++;
                if (m_first) begin
                    m_mode = mode_i; m_ctr = iv_i; m_ctr8 = iv_i;
                end
                cin  = m_mode ? m_ctr  : s_data_i;
                cin8 = m_mode ? m_ctr8 : s_data_i;
                res  = m_mode ? (core_f(cin) ^ s_data_i) : core_f(s_data_i);
                q_cin.push_back(cin);
                q_cin8.push_back(cin8);
                q_out.push_back({s_last_i, res});
                m_ctr  = {m_ctr[127:64], m_ctr[63:0] + 64'd1};
                m_ctr8 = {m_ctr8[127:8], m_ctr8[7:0] + 8'd1};
                m_first = s_last_i;
            end
            m_n = m_n + int'(push) - int'(pop);
            if (m_ack_due) m_txn = 1'b0;
            if (acc) m_txn = 1'b1;
            if (m_req_due) m_wait = 1'b1;
            if (push) m_wait = 1'b0;
            m_ack_due = push;
            m_req_due = acc;
        end
    end

    // Random downstream back-pressure when enabled.
    logic rr_en = 1'b0;
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rr_en) m_ready_i = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [127:0] d, input logic l, input logic md,
                        input logic [127:0] iv, input int unsigned maxc, output logic ok);
        s_valid_i = 1'b1; s_data_i = d; s_last_i = l; mode_i = md; iv_i = iv; ok = 1'b0;
        for (int unsigned c = 0; c < maxc; c++) begin
            @(negedge clk);
            if (s_ready_o) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        s_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input string nm, input int unsigned maxc);
        logic done;
        done = 1'b0;
        for (int unsigned c = 0; c < maxc; c++) begin
            @(negedge clk);
            if (q_out.size() == 0 && !m_txn) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk(nm, 129'(0), 129'(1));
        @(posedge clk); #1;
    endtask

    function automatic logic [128:0] out_at(input int idx);
        return (idx < out_log.size()) ? out_log[idx] : 'x;
    endfunction

    function automatic logic [127:0] req_at(input int idx, input logic narrow);
        if (narrow) return (idx < req8_log.size()) ? req8_log[idx] : 'x;
        return (idx < req_log.size()) ? req_log[idx] : 'x;
    endfunction

    // ---------------- directed and random sequence ----------------
    initial begin
        logic ok;
        int base, rb, ab, nacc, a0;
        logic [127:0] blk [DEPTH+2];
        logic [127:0] xd;
        rst = 1'b1; mode_i = 1'b0; iv_i = '0; s_valid_i = 1'b0; s_data_i = '0;
        s_last_i = 1'b0; m_ready_i = 1'b1; core_busy_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // ECB single block with the GOST vector
        base = out_log.size(); rb = req_cnt; ab = ack_cnt;
        send(GOST_PT, 1'b1, 1'b0, rand128(), 50, ok);
        chk("gost_accept", 129'(ok), 129'(1));
        wait_drain("gost_drain", 100);
        chk("gost_out", out_at(base), {1'b1, GOST_CT});
        chk("gost_req_pulses", 129'(req_cnt - rb), 129'(1));
        chk("gost_ack_pulses", 129'(ack_cnt - ab), 129'(1));

        // CTR 3-block message; mode/iv presented mid-message must be ignored
        rb = req_log.size();
        send(rand128(), 1'b0, 1'b1, IV1, 50, ok);
        send(rand128(), 1'b0, 1'b0, rand128(), 50, ok);
        send(rand128(), 1'b1, 1'b0, rand128(), 50, ok);
        wait_drain("ctr3_drain", 100);
        chk("ctr3_cnt0", 129'(req_at(rb, 1'b0)), 129'(IV1));
        chk("ctr3_cnt1", 129'(req_at(rb + 1, 1'b0)), 129'(128'h1234567890abcef0_0000000000000001));
        chk("ctr3_cnt2", 129'(req_at(rb + 2, 1'b0)), 129'(128'h1234567890abcef0_0000000000000002));
        chk("ctr3_cnt2_w8", 129'(req_at(rb + 2, 1'b1)), 129'(128'h1234567890abcef0_0000000000000002));

        // New message reloads a new IV; low-byte wrap in the narrow counter
        rb = req_log.size();
        send(rand128(), 1'b0, 1'b1, IV2, 50, ok);
        send(rand128(), 1'b1, 1'b0, '1, 50, ok);
        wait_drain("iv2_drain", 100);
        chk("iv2_reload", 129'(req_at(rb, 1'b0)), 129'(IV2));
        chk("iv2_cnt1_w64", 129'(req_at(rb + 1, 1'b0)), 129'(128'hfedcba9876543210_0000000000000100));
        chk("iv2_cnt1_w8", 129'(req_at(rb + 1, 1'b1)), 129'(128'hfedcba9876543210_0000000000000000));

        // Back-pressure: DEPTH+2 ECB blocks with the output stalled
        for (int i = 0; i < DEPTH + 2; i++) blk[i] = rand128();
        base = out_log.size();
        m_ready_i = 1'b0;
        nacc = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            send(blk[i], 1'(i == DEPTH + 1), 1'b0, '0, 30, ok);
            if (!ok) break;
            nacc++;
        end
        chk("bp_accepted", 129'(nacc), 129'(DEPTH));
        @(negedge clk);
        chk("bp_ready_low", 129'(s_ready_o), 129'(0));
        @(posedge clk); #1;
        m_ready_i = 1'b1;
        for (int i = nacc; i < DEPTH + 2; i++) begin
            send(blk[i], 1'(i == DEPTH + 1), 1'b0, '0, 100, ok);
            chk("bp_late_accept", 129'(ok), 129'(1));
        end
        wait_drain("bp_drain", 200);
        for (int i = 0; i < DEPTH + 2; i++)
            chk("bp_order", out_at(base + i), {1'(i == DEPTH + 1), core_f(blk[i])});

        // core_busy holds off acceptance; stray core_valid in IDLE is ignored
        xd = rand128();
        base = out_log.size(); a0 = acc_cnt; rb = req_cnt;
        core_busy_i = 1'b1;
        s_valid_i = 1'b1; s_data_i = xd; s_last_i = 1'b1; mode_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            stray = (c == 3);
            @(posedge clk); #1;
        end
        stray = 1'b0;
        chk("busy_no_accept", 129'(acc_cnt - a0), 129'(0));
        chk("busy_no_request", 129'(req_cnt - rb), 129'(0));
        core_busy_i = 1'b0;
        @(negedge clk);
        chk("busy_release_ready", 129'(s_ready_o), 129'(1));
        @(posedge clk); #1;
        s_valid_i = 1'b0;
        wait_drain("busy_drain", 100);
        chk("busy_out", out_at(base), {1'b1, core_f(xd)});
        chk("busy_single", 129'(out_log.size() - base), 129'(1));

        // Reset while a block waits on the core and another sits in the FIFO
        m_ready_i = 1'b0;
        lat_fix = 8;
        send(rand128(), 1'b0, 1'b1, rand128(), 50, ok);
        send(rand128(), 1'b0, 1'b1, rand128(), 50, ok);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        chk("rstmid_fifo_empty", 129'(m_valid_o), 129'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        lat_fix = -1;
        m_ready_i = 1'b1;
        @(negedge clk);
        chk("rstmid_flushed", 129'(m_valid_o), 129'(0));
        @(posedge clk); #1;
        rb = req_log.size();
        xd = rand128();
        send(rand128(), 1'b1, 1'b1, xd, 50, ok);
        wait_drain("rstmid_drain", 100);
        chk("rstmid_iv_reload", 129'(req_at(rb, 1'b0)), 129'(xd));

        // Randomized traffic with random back-pressure and core latency
        rr_en = 1'b1;
        for (int i = 0; i < 80; i++) begin
            send(rand128(), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 rand128(), 200, ok);
            chk("rand_accept", 129'(ok), 129'(1));
        end
        send(rand128(), 1'b1, 1'b1, rand128(), 200, ok);
        rr_en = 1'b0;
        m_ready_i = 1'b1;
        wait_drain("rand_drain", 300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
